// File: rtl/sr_cfg_pkg.sv
// sr_cfg_pkg: shared constants, state encoding and field map for the serial configuration link
package sr_cfg_pkg;
  localparam int N_BITS_DEF = 18;
  localparam int DT_LSB = 0;
  localparam int DT_MSB = 4;
  localparam int SEL_GEN1_LSB = 5;
  localparam int SEL_GEN1_MSB = 6;
  localparam int SEL_GEN2_LSB = 7;
  localparam int SEL_GEN2_MSB = 8;
  localparam int OUT_SEL_EXT_LSB = 9;
  localparam int OUT_SEL_EXT_MSB = 12;
  localparam int INPUT_SEL_BIT = 13;
  localparam int CLK_SEL_BIT = 14;
  localparam int PS_SEL_BIT = 15;
  localparam int PS3_SEL_BIT = 16;
  localparam int ENABLE_OUTPUT_BIT = 17;
  typedef enum logic [2:0] {S_IDLE, S_SRST, S_LOW, S_HIGH, S_FIN} state_t;
  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/sr_phase_timer.sv
// sr_phase_timer: loadable down-counter flagging the last clock of a phase
module sr_phase_timer #(
  parameter int W = 2
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         LOAD,
  input  logic [W-1:0] LOAD_VAL,
  output logic         EXPIRED
);
  logic [W-1:0] cnt;
  assign EXPIRED = cnt == '0;
  // load holds for LOAD_VAL+1 clocks; counting stops at zero
  always_ff @(posedge CLK) begin
    if (!RST_N) cnt <= '0;
    else if (LOAD) cnt <= LOAD_VAL;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  end
endmodule

// File: rtl/sr_config_tx.sv
// sr_config_tx: serializes a configuration word LSB first onto CLK_SR_OUT/DATA_OUT after a receiver reset
module sr_config_tx #(
  parameter int N_BITS      = sr_cfg_pkg::N_BITS_DEF,
  parameter int HALF_PERIOD = 2,
  parameter int RST_CYCLES  = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic [N_BITS-1:0] CFG_DATA,
  output logic              CLK_SR_OUT,
  output logic              SR_RST_OUT,
  output logic              DATA_OUT,
  output logic              BUSY,
  output logic              DONE
);
  import sr_cfg_pkg::*;
  localparam int IW = $clog2(N_BITS);
  localparam int PW = $clog2(max2(HALF_PERIOD, RST_CYCLES) + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_BITS - 1);
  localparam logic [PW-1:0] RST_LOAD = PW'(RST_CYCLES - 1);
  localparam logic [PW-1:0] HP_LOAD  = PW'(HALF_PERIOD - 1);
  state_t            state;
  logic [N_BITS-1:0] shadow;
  logic [IW-1:0]     bit_idx;
  logic [IW-1:0]     nxt_idx;
  logic              load;
  logic              expired;
  logic [PW-1:0]     load_val;
  assign nxt_idx = bit_idx + 1'b1;
  // restart the phase timer on every state entry that has a timed phase
  always_comb begin
    load = 1'b0;
    load_val = HP_LOAD;
    load = (state == S_IDLE && START) ||
           (expired && (state == S_SRST || state == S_LOW || (state == S_HIGH && bit_idx != LAST_IDX)));
    load_val = state == S_IDLE ? RST_LOAD : HP_LOAD;
  end
  sr_phase_timer #(.W(PW)) u_timer (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .LOAD     (load),
    .LOAD_VAL (load_val),
    .EXPIRED  (expired)
  );
  // transfer sequencer; every output is a register updated on state transitions
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state      <= S_IDLE;
      shadow     <= '0;
      bit_idx    <= '0;
      CLK_SR_OUT <= 1'b0;
      SR_RST_OUT <= 1'b0;
      DATA_OUT   <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (START) begin
          shadow     <= CFG_DATA;
          BUSY       <= 1'b1;
          SR_RST_OUT <= 1'b1;
          state      <= S_SRST;
        end
        S_SRST: if (expired) begin
          SR_RST_OUT <= 1'b0;
          bit_idx    <= '0;
          DATA_OUT   <= shadow[0];
          state      <= S_LOW;
        end
        S_LOW: if (expired) begin
          CLK_SR_OUT <= 1'b1;
          state      <= S_HIGH;
        end
        S_HIGH: if (expired) begin
          CLK_SR_OUT <= 1'b0;
          if (bit_idx == LAST_IDX) begin
            DATA_OUT <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b1;
            state    <= S_FIN;
          end else begin
            bit_idx  <= nxt_idx;
            DATA_OUT <= shadow[nxt_idx];
            state    <= S_LOW;
          end
        end
        S_FIN: begin
          DONE  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sr_config_tx.sv
// tb_sr_config_tx: randomized self-checking bench with a behavioural shift-register receiver
module tb_sr_config_tx;
  localparam int NB = 18;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start;
  logic [NB-1:0] cfg;
  logic clk_sr, sr_rst, dout, busy, done;
  logic rst_n_b, start_b;
  logic [NB-1:0] cfg_b;
  logic clk_sr_b, sr_rst_b, dout_b, busy_b, done_b;

  sr_config_tx dut (
    .CLK(clk), .RST_N(rst_n), .START(start), .CFG_DATA(cfg),
    .CLK_SR_OUT(clk_sr), .SR_RST_OUT(sr_rst), .DATA_OUT(dout), .BUSY(busy), .DONE(done)
  );
  sr_config_tx #(.N_BITS(NB), .HALF_PERIOD(1), .RST_CYCLES(1)) dut_b (
    .CLK(clk), .RST_N(rst_n_b), .START(start_b), .CFG_DATA(cfg_b),
    .CLK_SR_OUT(clk_sr_b), .SR_RST_OUT(sr_rst_b), .DATA_OUT(dout_b), .BUSY(busy_b), .DONE(done_b)
  );

  int checks = 0;
  int fails = 0;

  function automatic int latency(input int hp, input int rc);
    return rc + 2 * hp * NB;
  endfunction

  // receiver and protocol monitor for the default instance
  int cyc = 0, edges = 0, hold_viol = 0, overlap = 0, srst_run = 0, srst_len = 0;
  int busy_rise = 0, done_cyc = 0, done_cnt = 0;
  logic [NB-1:0] rx_word = '0;
  logic p_clk_sr = 1'b0, p_dout = 1'b0, p_busy = 1'b0, p_done = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (sr_rst === 1'b1) begin rx_word = '0; srst_run++; end
    else if (srst_run != 0) begin srst_len = srst_run; srst_run = 0; end
    if (clk_sr === 1'b1 && p_clk_sr !== 1'b1) begin rx_word = {dout, rx_word[NB-1:1]}; edges++; end
    if (clk_sr === 1'b1 && p_clk_sr === 1'b1 && dout !== p_dout) hold_viol++;
    if (clk_sr === 1'b1 && sr_rst === 1'b1) overlap++;
    if (busy === 1'b1 && p_busy !== 1'b1) busy_rise = cyc;
    if (done === 1'b1 && p_done !== 1'b1) begin done_cyc = cyc; done_cnt++; end
    p_clk_sr = clk_sr; p_dout = dout; p_busy = busy; p_done = done;
  end

  // receiver and protocol monitor for the fast instance
  int cyc_b = 0, edges_b = 0, busy_rise_b = 0, done_cyc_b = 0;
  logic [NB-1:0] rx_b = '0;
  logic p_clk_sr_b = 1'b0, p_busy_b = 1'b0, p_done_b = 1'b0;
  always @(negedge clk) begin
    cyc_b++;
    if (sr_rst_b === 1'b1) rx_b = '0;
    if (clk_sr_b === 1'b1 && p_clk_sr_b !== 1'b1) begin rx_b = {dout_b, rx_b[NB-1:1]}; edges_b++; end
    if (busy_b === 1'b1 && p_busy_b !== 1'b1) busy_rise_b = cyc_b;
    if (done_b === 1'b1 && p_done_b !== 1'b1) done_cyc_b = cyc_b;
    p_clk_sr_b = clk_sr_b; p_busy_b = busy_b; p_done_b = done_b;
  end

  task automatic start_a(input logic [NB-1:0] w);
    @(negedge clk); #1;
    cfg = w; start = 1'b1; edges = 0; hold_viol = 0; overlap = 0;
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_a(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (done === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b1; cfg = 18'h3FFFF;
    rst_n_b = 1'b0; start_b = 1'b1; cfg_b = 18'h3FFFF;
    repeat (3) begin
      @(negedge clk); #1;
      checks++;
      if ({clk_sr, sr_rst, dout, busy, done} !== 5'b0) begin
        fails++; $display("FAIL reset_outputs: got %b expected 00000", {clk_sr, sr_rst, dout, busy, done});
      end
      checks++;
      if ({clk_sr_b, sr_rst_b, dout_b, busy_b, done_b} !== 5'b0) begin
        fails++; $display("FAIL reset_outputs_b: got %b expected 00000", {clk_sr_b, sr_rst_b, dout_b, busy_b, done_b});
      end
    end
    checks++;
    if (edges != 0) begin fails++; $display("FAIL reset_edges: got %0d expected 0", edges); end
    start = 1'b0; start_b = 1'b0; rst_n = 1'b1; rst_n_b = 1'b1;
  endtask

  task automatic test_pattern;
    bit ok;
    start_a(18'h2A5C3);
    wait_a(ok);
    checks++;
    if (!ok) begin fails++; $display("FAIL pattern_done: got timeout expected DONE"); end
    checks++;
    if (done_cyc - busy_rise != latency(2, 2)) begin
      fails++; $display("FAIL pattern_latency: got %0d expected %0d", done_cyc - busy_rise, latency(2, 2));
    end
    checks++;
    if (rx_word !== 18'h2A5C3) begin fails++; $display("FAIL pattern_word: got %h expected 2a5c3", rx_word); end
    checks++;
    if (edges != NB) begin fails++; $display("FAIL pattern_edges: got %0d expected %0d", edges, NB); end
    checks++;
    if (hold_viol != 0) begin fails++; $display("FAIL pattern_hold: got %0d data changes while high expected 0", hold_viol); end
    checks++;
    if (overlap != 0) begin fails++; $display("FAIL pattern_overlap: got %0d expected 0", overlap); end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int d;
    start_a(18'h00000);
    wait_a(ok);
    checks++;
    if (!ok || rx_word !== 18'h00000) begin fails++; $display("FAIL b2b_zero_word: got %h ok=%0d expected 00000", rx_word, ok); end
    checks++;
    if (srst_len != 2) begin fails++; $display("FAIL b2b_srst_len1: got %0d expected 2", srst_len); end
    // START already high in the DONE cycle: only the following IDLE cycle may accept it
    d = done_cyc;
    cfg = 18'h3FFFF; start = 1'b1; edges = 0; hold_viol = 0;
    @(negedge clk); #1;
    @(negedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy_rise != d + 2) begin fails++; $display("FAIL b2b_accept: got busy at +%0d expected +2", busy_rise - d); end
    wait_a(ok);
    checks++;
    if (!ok || rx_word !== 18'h3FFFF) begin fails++; $display("FAIL b2b_ones_word: got %h ok=%0d expected 3ffff", rx_word, ok); end
    checks++;
    if (srst_len != 2) begin fails++; $display("FAIL b2b_srst_len2: got %0d expected 2", srst_len); end
    checks++;
    if (edges != NB || hold_viol != 0) begin fails++; $display("FAIL b2b_edges: got %0d edges %0d hold errors expected %0d 0", edges, hold_viol, NB); end
  endtask

  task automatic test_ignored_inputs;
    bit ok;
    int n;
    n = done_cnt;
    start_a(18'h15555);
    repeat (20) @(negedge clk);
    #1;
    start = 1'b1; cfg = 18'h00001;
    repeat (3) @(negedge clk);
    #1;
    start = 1'b0;
    wait_a(ok);
    checks++;
    if (!ok || rx_word !== 18'h15555) begin fails++; $display("FAIL ignored_word: got %h ok=%0d expected 15555", rx_word, ok); end
    repeat (6) @(negedge clk);
    #1;
    checks++;
    if (done_cnt != n + 1 || busy !== 1'b0) begin
      fails++; $display("FAIL ignored_single_done: got %0d dones busy=%b expected 1 busy=0", done_cnt - n, busy);
    end
  endtask

  task automatic test_mid_reset;
    bit ok;
    bit hit;
    start_a(NB'($urandom));
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (edges == 7) begin hit = 1'b1; break; end
    end
    checks++;
    if (!hit) begin fails++; $display("FAIL midrst_progress: got %0d edges expected 7", edges); end
    rst_n = 1'b0;
    @(negedge clk); #1;
    checks++;
    if ({clk_sr, sr_rst, dout, busy, done} !== 5'b0) begin
      fails++; $display("FAIL midrst_outputs: got %b expected 00000", {clk_sr, sr_rst, dout, busy, done});
    end
    rst_n = 1'b1;
    start_a(18'h0000F);
    wait_a(ok);
    checks++;
    if (!ok || rx_word !== 18'h0000F) begin fails++; $display("FAIL midrst_word: got %h ok=%0d expected 0000f", rx_word, ok); end
    checks++;
    if (edges != NB || done_cyc - busy_rise != latency(2, 2)) begin
      fails++; $display("FAIL midrst_timing: got %0d edges latency %0d expected %0d %0d", edges, done_cyc - busy_rise, NB, latency(2, 2));
    end
  endtask

  task automatic test_random;
    bit ok;
    logic [NB-1:0] w;
    for (int k = 0; k < 4; k++) begin
      w = NB'($urandom);
      start_a(w);
      wait_a(ok);
      checks++;
      if (!ok || rx_word !== w) begin fails++; $display("FAIL random_word%0d: got %h ok=%0d expected %h", k, rx_word, ok, w); end
      checks++;
      if (edges != NB || hold_viol != 0 || overlap != 0 || done_cyc - busy_rise != latency(2, 2)) begin
        fails++; $display("FAIL random_proto%0d: got edges %0d hold %0d overlap %0d latency %0d expected %0d 0 0 %0d",
                          k, edges, hold_viol, overlap, done_cyc - busy_rise, NB, latency(2, 2));
      end
    end
  endtask

  task automatic test_param_sweep;
    bit ok;
    logic [NB-1:0] w;
    for (int k = 0; k < 2; k++) begin
      w = (k == 0) ? 18'h3C3C3 : NB'($urandom);
      @(negedge clk); #1;
      cfg_b = w; start_b = 1'b1; edges_b = 0;
      @(negedge clk); #1;
      start_b = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk); #1;
        if (done_b === 1'b1) begin ok = 1'b1; break; end
      end
      checks++;
      if (!ok || done_cyc_b - busy_rise_b != latency(1, 1)) begin
        fails++; $display("FAIL sweep_latency%0d: got %0d ok=%0d expected %0d", k, done_cyc_b - busy_rise_b, ok, latency(1, 1));
      end
      checks++;
      if (rx_b !== w || edges_b != NB) begin
        fails++; $display("FAIL sweep_word%0d: got %h edges %0d expected %h %0d", k, rx_b, edges_b, w, NB);
      end
    end
  endtask

  initial begin
    test_reset();
    test_pattern();
    test_back_to_back();
    test_ignored_inputs();
    test_mid_reset();
    test_random();
    test_param_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
